// File: rtl/irq_trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode interrupt entry/return sequencer.
// Provides DATA_WIDTH/ZERO fallbacks when the surrounding codebase has not defined them.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZERO
`define ZERO {`DATA_WIDTH{1'b0}}
`endif

package irq_trap_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MSTATUS,
    S_W_MEPC,
    S_W_MCAUSE,
    S_JUMP,
    S_MRET_WR,
    S_MRET_JUMP
  } state_e;

  localparam logic [`DATA_WIDTH-1:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [`DATA_WIDTH-1:0] CAUSE_MTI = 32'h8000_0007;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;

endpackage

// File: rtl/irq_trap_ctrl_irq_sync.sv
// Single register stage for the CLINT interrupt levels before the trap decision.
module irq_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic timer_irq_i,
  input  logic software_irq_i,
  output logic mtip_q,
  output logic msip_q
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      mtip_q <= timer_irq_i;
      msip_q <= software_irq_i;
    end
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Interrupt entry / mret sequencer: writes mstatus, mepc, mcause then redirects fetch.
// Build option IRQ_VECTORED_EN enables mtvec vectored mode (mode 2'b01) for interrupts.
//
// state       | meaning
// S_IDLE      | waiting for mret or an enabled, pending interrupt at a precise boundary
// S_W_MSTATUS | writing entry mstatus image (MPIE=MIE, MIE=0)
// S_W_MEPC    | writing latched epc
// S_W_MCAUSE  | writing latched cause
// S_JUMP      | flush and redirect to trap vector
// S_MRET_WR   | writing return mstatus image (MIE=MPIE, MPIE=1)
// S_MRET_JUMP | flush and redirect to mepc
module irq_trap_ctrl
  import irq_trap_ctrl_pkg::*;
#(
  parameter logic [11:0] MSTATUS_ADDR = CSR_MSTATUS,
  parameter logic [11:0] MEPC_ADDR    = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR  = CSR_MCAUSE
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   timer_irq_i,
  input  logic                   software_irq_i,
  input  logic [`DATA_WIDTH-1:0] mstatus_i,
  input  logic [`DATA_WIDTH-1:0] mie_i,
  input  logic [`DATA_WIDTH-1:0] mtvec_i,
  input  logic [`DATA_WIDTH-1:0] mepc_i,
  input  logic [`DATA_WIDTH-1:0] inst_addr_i,
  input  logic                   inst_valid_i,
  input  logic                   mret_i,
  output logic                   csr_we_o,
  output logic [11:0]            csr_waddr_o,
  output logic [`DATA_WIDTH-1:0] csr_wdata_o,
  output logic                   hold_o,
  output logic                   flush_o,
  output logic [`DATA_WIDTH-1:0] redirect_addr_o
);

  state_e                 state_q, state_d;
  logic                   msip_q, mtip_q;
  logic                   pend_sw, pend_tm, take;
  logic [`DATA_WIDTH-1:0] cause_q, epc_q, cause_d;
  logic                   we_d;
  logic [11:0]            waddr_d;
  logic [`DATA_WIDTH-1:0] wdata_d;
  logic [`DATA_WIDTH-1:0] entry_img, mret_img, vec_base, vec_addr;
  logic                   unused_bits;

  irq_sync u_irq_sync (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .timer_irq_i    (timer_irq_i),
    .software_irq_i (software_irq_i),
    .mtip_q         (mtip_q),
    .msip_q         (msip_q)
  );

  assign pend_sw = msip_q & mie_i[MIE_MSIE];
  assign pend_tm = mtip_q & mie_i[MIE_MTIE];
  assign take    = (state_q == S_IDLE) & ~mret_i & mstatus_i[MSTATUS_MIE]
                 & (pend_sw | pend_tm) & inst_valid_i;
  assign cause_d = pend_sw ? CAUSE_MSI : CAUSE_MTI;

  always_comb begin
    entry_img               = mstatus_i;
    entry_img[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
    entry_img[MSTATUS_MIE]  = 1'b0;
    mret_img                = mstatus_i;
    mret_img[MSTATUS_MIE]   = mstatus_i[MSTATUS_MPIE];
    mret_img[MSTATUS_MPIE]  = 1'b1;
  end

  assign vec_base = {mtvec_i[`DATA_WIDTH-1:2], 2'b00};
`ifdef IRQ_VECTORED_EN
  assign vec_addr = (mtvec_i[1:0] == 2'b01)
                  ? vec_base + ({1'b0, cause_q[`DATA_WIDTH-2:0]} << 2)
                  : vec_base;
`else
  assign vec_addr = vec_base;
`endif
  assign unused_bits = ^{mie_i, mtvec_i[1:0]};

  // CSR write port is registered, so write strobe/data are decided from the next state.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = 12'h000;
    wdata_d = `ZERO;
    case (state_q)
      S_IDLE: begin
        if (mret_i) begin
          state_d = S_MRET_WR;
          we_d    = 1'b1;
          waddr_d = MSTATUS_ADDR;
          wdata_d = mret_img;
        end else if (take) begin
          state_d = S_W_MSTATUS;
          we_d    = 1'b1;
          waddr_d = MSTATUS_ADDR;
          wdata_d = entry_img;
        end
      end
      S_W_MSTATUS: begin
        state_d = S_W_MEPC;
        we_d    = 1'b1;
        waddr_d = MEPC_ADDR;
        wdata_d = epc_q;
      end
      S_W_MEPC: begin
        state_d = S_W_MCAUSE;
        we_d    = 1'b1;
        waddr_d = MCAUSE_ADDR;
        wdata_d = cause_q;
      end
      S_W_MCAUSE:  state_d = S_JUMP;
      S_JUMP:      state_d = S_IDLE;
      S_MRET_WR:   state_d = S_MRET_JUMP;
      S_MRET_JUMP: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= 12'h000;
      csr_wdata_o <= `ZERO;
      cause_q     <= `ZERO;
      epc_q       <= `ZERO;
    end else begin
      state_q     <= state_d;
      csr_we_o    <= we_d;
      csr_waddr_o <= waddr_d;
      csr_wdata_o <= wdata_d;
      if (take) begin
        cause_q <= cause_d;
        epc_q   <= inst_addr_i;
      end
    end
  end

  assign flush_o         = (state_q == S_JUMP) | (state_q == S_MRET_JUMP);
  assign redirect_addr_o = (state_q == S_JUMP)      ? vec_addr :
                           (state_q == S_MRET_JUMP) ? mepc_i   : `ZERO;
  assign hold_o          = take | (state_q != S_IDLE) | mret_i;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Directed bench for irq_trap_ctrl: vector table for the entry decision plus hand sequences.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module tb_irq_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        timer_irq_i = 1'b0, software_irq_i = 1'b0;
  logic [31:0] mstatus_i = '0, mie_i = '0, mtvec_i = '0, mepc_i = '0, inst_addr_i = '0;
  logic        inst_valid_i = 1'b0, mret_i = 1'b0;
  logic        csr_we_o, hold_o, flush_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o, redirect_addr_o;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef IRQ_VECTORED_EN
  localparam logic [31:0] EXP_VEC_B = 32'h0000_010C;
`else
  localparam logic [31:0] EXP_VEC_B = 32'h0000_0100;
`endif

  irq_trap_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .timer_irq_i     (timer_irq_i),
    .software_irq_i  (software_irq_i),
    .mstatus_i       (mstatus_i),
    .mie_i           (mie_i),
    .mtvec_i         (mtvec_i),
    .mepc_i          (mepc_i),
    .inst_addr_i     (inst_addr_i),
    .inst_valid_i    (inst_valid_i),
    .mret_i          (mret_i),
    .csr_we_o        (csr_we_o),
    .csr_waddr_o     (csr_waddr_o),
    .csr_wdata_o     (csr_wdata_o),
    .hold_o          (hold_o),
    .flush_o         (flush_o),
    .redirect_addr_o (redirect_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        sw, tm, valid, mret;
    logic [31:0] mstatus, mie;
    logic        exp_hold, exp_we;
    logic [11:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input string name, input logic we, input logic [11:0] addr,
                     input logic [31:0] data, input logic hold, input logic flush,
                     input logic [31:0] redir);
    chk({name, "_we"},    {31'd0, csr_we_o},  {31'd0, we});
    chk({name, "_addr"},  {20'd0, csr_waddr_o}, {20'd0, addr});
    chk({name, "_data"},  csr_wdata_o, data);
    chk({name, "_hold"},  {31'd0, hold_o},    {31'd0, hold});
    chk({name, "_flush"}, {31'd0, flush_o},   {31'd0, flush});
    chk({name, "_redir"}, redirect_addr_o, redir);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [31:0] ms, input logic [31:0] me, input logic [31:0] tv,
                       input logic [31:0] ia);
    rst_i = 1'b0;
    mret_i = 1'b0; timer_irq_i = 1'b0; software_irq_i = 1'b0;
    mstatus_i = ms; mie_i = me; mtvec_i = tv; inst_addr_i = ia;
    inst_valid_i = 1'b1; mepc_i = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    //            sw    tm    valid mret  mstatus       mie           hold  we    addr     data
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0080, 1'b1, 1'b1, 12'h300, 32'h0000_0080};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0088, 1'b1, 1'b1, 12'h300, 32'h0000_0080};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0080, 1'b0, 1'b0, 12'h000, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 1'b0, 12'h000, 32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0080, 1'b0, 1'b0, 12'h000, 32'h0000_0000};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0008, 1'b1, 1'b1, 12'h300, 32'h0000_0080};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0000, 1'b1, 1'b1, 12'h300, 32'h0000_0088};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b1, 1'b1, 12'h300, 32'h0000_0080};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0080, 1'b0, 1'b0, 12'h000, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1808, 32'h0000_0080, 1'b1, 1'b1, 12'h300, 32'h0000_1880};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0088, 32'h0000_0080, 1'b1, 1'b1, 12'h300, 32'h0000_0088};

    #1;
    cyc("reset", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 11; i++) begin
      start(vecs[i].mstatus, vecs[i].mie, 32'h100, 32'h80);
      software_irq_i = vecs[i].sw;
      timer_irq_i    = vecs[i].tm;
      inst_valid_i   = vecs[i].valid;
      tick();
      mret_i = vecs[i].mret;
      #1;
      chk($sformatf("vec%0d_hold", i), {31'd0, hold_o}, {31'd0, vecs[i].exp_hold});
      tick();
      mret_i = 1'b0;
      chk($sformatf("vec%0d_we", i),   {31'd0, csr_we_o},    {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_addr", i), {20'd0, csr_waddr_o}, {20'd0, vecs[i].exp_addr});
      chk($sformatf("vec%0d_data", i), csr_wdata_o, vecs[i].exp_data);
    end

    // Timer pulse entry; inputs change after take and must not affect the sequence.
    start(32'h8, 32'h80, 32'h100, 32'h80);
    tick();
    chk("A_pre_hold", {31'd0, hold_o}, 32'd0);
    timer_irq_i = 1'b1;
    tick();
    timer_irq_i = 1'b0;
    chk("A_take_hold", {31'd0, hold_o}, 32'd1);
    tick(); cyc("A_wmstatus", 1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    inst_addr_i = 32'h200; mie_i = 32'h0; mstatus_i = 32'h0;
    tick(); cyc("A_wmepc",    1'b1, 12'h341, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    tick(); cyc("A_wmcause",  1'b1, 12'h342, 32'h8000_0007, 1'b1, 1'b0, 32'h0);
    tick(); cyc("A_jump",     1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 32'h100);
    tick(); cyc("A_idle",     1'b0, 12'h000, 32'h0,         1'b0, 1'b0, 32'h0);

    // Both lines high: software wins; lines stay high but MIE=0 blocks re-entry.
    start(32'h8, 32'h88, 32'h101, 32'h40);
    software_irq_i = 1'b1; timer_irq_i = 1'b1;
    tick();
    chk("B_take_hold", {31'd0, hold_o}, 32'd1);
    tick(); cyc("B_wmstatus", 1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    tick(); cyc("B_wmepc",    1'b1, 12'h341, 32'h0000_0040, 1'b1, 1'b0, 32'h0);
    tick(); cyc("B_wmcause",  1'b1, 12'h342, 32'h8000_0003, 1'b1, 1'b0, 32'h0);
    tick(); cyc("B_jump",     1'b0, 12'h000, 32'h0,         1'b1, 1'b1, EXP_VEC_B);
    mstatus_i = 32'h80;
    for (int k = 0; k < 4; k++) begin
      tick();
      cyc($sformatf("B_masked%0d", k), 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    end

    // MIE=0 with timer high, then MIE set: immediate take, write on next edge.
    start(32'h0, 32'h80, 32'h100, 32'h80);
    timer_irq_i = 1'b1;
    tick(); chk("C_off_hold0", {31'd0, hold_o}, 32'd0);
    tick(); chk("C_off_hold1", {31'd0, hold_o}, 32'd0);
    chk("C_off_we", {31'd0, csr_we_o}, 32'd0);
    mstatus_i = 32'h8;
    #1; chk("C_on_hold", {31'd0, hold_o}, 32'd1);
    tick(); cyc("C_wmstatus", 1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);

    // mret beats a pending timer interrupt; the interrupt is taken after returning to IDLE.
    start(32'h88, 32'h80, 32'h100, 32'h90);
    mepc_i = 32'h84; inst_valid_i = 1'b0; timer_irq_i = 1'b1;
    tick();
    chk("D_blocked_hold", {31'd0, hold_o}, 32'd0);
    inst_valid_i = 1'b1; mret_i = 1'b1;
    #1; chk("D_mret_hold", {31'd0, hold_o}, 32'd1);
    tick(); mret_i = 1'b0;
    cyc("D_mret_wr",   1'b1, 12'h300, 32'h0000_0088, 1'b1, 1'b0, 32'h0);
    tick(); cyc("D_mret_jump", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h84);
    tick(); cyc("D_idle_take", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0);
    tick(); cyc("D_wmstatus",  1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    tick(); cyc("D_wmepc",     1'b1, 12'h341, 32'h0000_0090, 1'b1, 1'b0, 32'h0);
    tick(); cyc("D_wmcause",   1'b1, 12'h342, 32'h8000_0007, 1'b1, 1'b0, 32'h0);

    // Reset during W_MEPC: outputs clear at once, no mcause write, then clean re-entry.
    start(32'h8, 32'h80, 32'h100, 32'h80);
    timer_irq_i = 1'b1;
    tick();
    tick(); cyc("E_wmstatus", 1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    tick(); cyc("E_wmepc",    1'b1, 12'h341, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    #2 rst_i = 1'b0;
    #1 cyc("E_rst_now",  1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); cyc("E_rst_held", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick(); chk("E_retake_hold", {31'd0, hold_o}, 32'd1);
    tick(); cyc("E_re_wmstatus", 1'b1, 12'h300, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    tick(); cyc("E_re_wmepc",    1'b1, 12'h341, 32'h0000_0080, 1'b1, 1'b0, 32'h0);
    tick(); cyc("E_re_wmcause",  1'b1, 12'h342, 32'h8000_0007, 1'b1, 1'b0, 32'h0);
    tick(); cyc("E_re_jump",     1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
